// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: mode encodings,
// packet-lock arbiter state encoding and the channel-count ceiling.
// The packet-lock feature is enabled by defining MUX_PKT_LOCK_EN.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MAX_N = 16;

    typedef enum logic {
        ARB_S    = 1'b0,
        LOCKED_S = 1'b1
    } arb_state_e;

    // True when idx names an existing channel of an n-channel mux.
    function automatic logic ch_in_range(input int idx, input int n);
        return (idx >= 0) && (idx < n);
    endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Round-robin grant finder: picks the first requesting channel at or after
// ptr, wrapping modulo N. Purely combinational; ptr must be < N.
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_vld
);

    logic [SELW:0] cand;

    // Scan from the furthest offset back toward ptr so the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = {1'b0, ptr} + (SELW + 1)'(off);
            if (cand >= (SELW + 1)'(N)) begin
                cand = cand - (SELW + 1)'(N);
            end
            if (req[cand[SELW-1:0]]) begin
                grant_idx = cand[SELW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_stream.sv
// N-to-1 valid/ready stream multiplexer with a single registered output
// stage. Channel chosen by SEL (MODE=0) or round-robin (MODE=1).
// Optional packet lock (keeps a round-robin grant until I_LAST) is enabled
// by defining MUX_PKT_LOCK_EN. RST_N asserts asynchronously; its release is
// expected to be synchronised to CLK upstream.
module mux_n_to_1_stream
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N*W-1:0]  I_DATA,
    input  logic [N-1:0]    I_VALID,
    output logic [N-1:0]    I_READY,
`ifdef MUX_PKT_LOCK_EN
    input  logic [N-1:0]    I_LAST,
    output logic            OUT_LAST,
`endif
    input  logic [SELW-1:0] SEL,
    input  logic            MODE,
    output logic [W-1:0]    OUT_DATA,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SELW-1:0] OUT_CH
);

    logic [W-1:0]    ch_data [N];
    logic            load_en;
    logic [SELW-1:0] arb_idx;
    logic            arb_vld;
    logic [SELW-1:0] grant_idx;
    logic            grant_vld;
    logic            rr_active;
    logic            xfer;

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;

`ifdef MUX_PKT_LOCK_EN
    arb_state_e      state_q, state_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic            out_last_q, out_last_d;
`endif

    function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] ch);
        return (ch == SELW'(N - 1)) ? '0 : ch + 1'b1;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign ch_data[k] = I_DATA[k*W +: W];
    end

    mux_rr_arbiter #(.N(N)) u_arb (
        .req       (I_VALID),
        .ptr       (ptr_q),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // The register accepts a beat when empty or being drained; never while in reset.
    assign load_en = RST_N && (!out_valid_q || OUT_READY);

    // Grant: fixed select, round-robin, or the locked packet channel.
    always_comb begin
        grant_idx = SEL;
        grant_vld = ch_in_range(int'(SEL), N);
        rr_active = (MODE == MODE_RR);
        if (MODE == MODE_RR) begin
            grant_idx = arb_idx;
            grant_vld = arb_vld;
        end
`ifdef MUX_PKT_LOCK_EN
        if (state_q == LOCKED_S) begin
            grant_idx = lock_ch_q;
            grant_vld = 1'b1;
            rr_active = 1'b1;
        end
`endif
    end

    // Only the granted channel sees ready, and only when the register can load.
    always_comb begin
        I_READY = '0;
        if (grant_vld && load_en) begin
            I_READY[grant_idx] = 1'b1;
        end
    end

    assign xfer = grant_vld && load_en && I_VALID[grant_idx];

    // Output register and round-robin pointer next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = ch_data[grant_idx];
            out_ch_d   = grant_idx;
            if (rr_active) begin
                ptr_d = next_ch(grant_idx);
            end
        end
    end

    // Registered output stage and arbitration pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    // Packet lock: a round-robin beat without LAST pins the grant until LAST.
    always_comb begin
        state_d    = state_q;
        lock_ch_d  = lock_ch_q;
        out_last_d = out_last_q;
        if (load_en) begin
            out_last_d = xfer && I_LAST[grant_idx];
        end
        if (xfer) begin
            case (state_q)
                ARB_S: begin
                    if ((MODE == MODE_RR) && !I_LAST[grant_idx]) begin
                        state_d   = LOCKED_S;
                        lock_ch_d = grant_idx;
                    end
                end
                LOCKED_S: begin
                    if (I_LAST[grant_idx]) begin
                        state_d = ARB_S;
                    end
                end
                default: state_d = ARB_S;
            endcase
        end
    end

    // Lock FSM state, locked channel and registered LAST flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ARB_S;
            lock_ch_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_ch_q  <= lock_ch_d;
            out_last_q <= out_last_d;
        end
    end

    assign OUT_LAST = out_last_q;
`endif

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_CH    = out_ch_q;

endmodule

// File: doc/mux_n_to_1_stream.md
Name: mux_n_to_1_stream

Overview:
Parametrised N-to-1 stream multiplexer and successor to the fixed 4:1 combinational mux. Selects one of N valid/ready input channels, either by explicit SEL or by round-robin arbitration. Drives a single registered output stage. Sits between per-channel producers and a shared downstream consumer.

Parameters:
N, 4, number of input channels (2..16)
W, 8, data width per channel
SELW, $clog2(N), select/channel-index width (localparam, derived)

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
I_DATA  input  N*W  channel k occupies bits [k*W +: W]
I_VALID  input  N  per-channel valid
I_READY  output  N  per-channel ready (combinational)
SEL  input  SELW  channel select, used when MODE=0
MODE  input  1  0 = fixed select, 1 = round-robin
OUT_DATA  output  W  registered data
OUT_VALID  output  1  registered valid
OUT_READY  input  1  downstream ready
OUT_CH  output  SELW  index of the channel that supplied OUT_DATA

Behaviour:
- Reset (async assert, sync release): OUT_VALID=0, OUT_DATA=0, OUT_CH=0, RR pointer=0.
- load_en = !OUT_VALID || OUT_READY. Single register stage, full throughput, latency 1 cycle from input handshake to OUT_VALID.
- Grant g is computed combinationally each cycle. I_READY[g]=load_en. Every other I_READY bit is 0.
- Transfer on channel g when I_VALID[g] && I_READY[g]. On transfer: OUT_DATA<=I_DATA[g], OUT_CH<=g, OUT_VALID<=1.
- When load_en=1 and no transfer occurs: OUT_VALID<=0. When load_en=0: the output register holds its value.
- MODE=0: g=SEL. If SEL>=N (non-power-of-2 N), there is no grant: all I_READY=0 and no load.
- MODE=1: g is the first k with I_VALID[k]=1, scanning ptr, ptr+1, ... with wrap mod N. After a transfer, ptr<=(g+1) mod N. With no valid inputs there is no grant and ptr is unchanged.
- SEL or MODE changes take effect at the next grant evaluation. The output register content is never altered by them.
- I_DATA/I_VALID must be held by the producer until its own handshake completes; the block never drops an accepted beat.
- OUT_READY=0 with OUT_VALID=1 stalls: OUT_DATA/OUT_CH remain stable and all I_READY=0.

Optional Feature:
MUX_PKT_LOCK_EN
- Defined: adds ports I_LAST (input, N) and OUT_LAST (output, 1, registered, reset 0). Adds a 2-state FSM, ARB then LOCKED, which applies in MODE=1 only.
  - ARB to LOCKED on a transfer with I_LAST[g]=0, latching lock_ch=g.
  - In LOCKED, g=lock_ch regardless of other valids.
  - LOCKED to ARB on a transfer with I_LAST[lock_ch]=1; ptr then advances to lock_ch+1.
  - A MODE change while LOCKED is ignored until packet end.
  - Reset returns the FSM to ARB.
- Undefined: the ports are absent and arbitration is per beat.

Decomposition:
- Package mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, arbiter state encoding (ARB_S, LOCKED_S), max-N constant 16.
- Sub-module mux_rr_arbiter (N parameter): inputs req[N], ptr; outputs grant_idx[SELW], grant_vld.
- Top holds the ptr, the optional lock FSM and the output register.

Test Plan:
- Reset: hold RST_N=0 with I_VALID=4'hF -> OUT_VALID=0, OUT_DATA=0, OUT_CH=0, I_READY=0. Release -> first beat appears 1 cycle after its handshake.
- Fixed select: MODE=0, SEL=2, I_DATA ch2=8'hA5, all valid, OUT_READY=1 -> I_READY=4'b0100. Next cycle OUT_DATA=8'hA5, OUT_CH=2.
- Round-robin fairness: MODE=1, all 4 valid continuously, OUT_READY=1 -> OUT_CH sequence 0,1,2,3,0,1. Drop ch1 valid -> sequence skips 1.
- Backpressure: OUT_READY=0 for 3 cycles with OUT_VALID=1 -> OUT_DATA/OUT_CH stable, I_READY=0. Release -> no beat lost or duplicated (scoreboard per channel).
- Invalid select: N=3, MODE=0, SEL=3 -> I_READY=3'b000. OUT_VALID falls after the drain.
- MUX_PKT_LOCK_EN: ch1 sends 3 beats, LAST on the third, while ch0/ch2 are valid -> OUT_CH=1,1,1 then 2. Async reset mid-packet -> FSM returns to ARB and OUT_LAST=0.
